// File: rtl/fft_mem_sched.sv
// Address scheduler for an in-place radix-2 DIT FFT over a dual-port working memory.
// Issues operand/twiddle reads, tracks butterflies in flight and writes results back in order.
module fft_mem_sched #(
  parameter int LOG2N      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Start,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Err,
  output logic [$clog2(LOG2N)-1:0]   Stage,
  output logic                       En,
  output logic                       We_A,
  output logic                       We_B,
  output logic [LOG2N-1:0]           Addr_A,
  output logic [LOG2N-1:0]           Addr_B,
  output logic [LOG2N-2:0]           Tw_Addr,
  output logic                       Bf_In_Valid,
  input  logic                       Bf_Res_Valid
);

  localparam int AW = LOG2N;
  localparam int JW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
  localparam logic [JW-1:0] LAST_J     = {JW{1'b1}};
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [SW:0]   JW_C       = (SW+1)'(JW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [JW-1:0] j_q, j_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          err_q, err_d;
  logic          bf_in_valid_q;
  logic [AW-1:0] fifo_q [FIFO_DEPTH];

  logic [AW-1:0] half_s, mask_s, j_ext_s, rd_a_s, head_a_s;
  logic [JW-1:0] pos_s;
  logic [SW:0]   tw_sh_s;
  logic          rd_slot_s, wr_slot_s, bad_res_s;

  // Butterfly j of stage s: A keeps the low s bits of j and shifts the group bits up by one.
  always_comb begin
    half_s   = AW'(1'b1) << stage_q;
    mask_s   = half_s - AW'(1'b1);
    j_ext_s  = {1'b0, j_q};
    rd_a_s   = ((j_ext_s & ~mask_s) << 1'b1) | (j_ext_s & mask_s);
    pos_s    = j_q & mask_s[JW-1:0];
    tw_sh_s  = JW_C - {1'b0, stage_q};
    head_a_s = fifo_q[rd_ptr_q];
  end

  // Slot arbitration: a returning result always takes the memory, a read otherwise waits.
  always_comb begin
    bad_res_s = Bf_Res_Valid && ((state_q == ST_IDLE) || (infl_q == {CW{1'b0}}));
    wr_slot_s = Bf_Res_Valid && !bad_res_s;
    rd_slot_s = (state_q == ST_RUN) && !Bf_Res_Valid && (infl_q < DEPTH_C);
    En        = wr_slot_s || rd_slot_s;
    We_A      = wr_slot_s;
    We_B      = wr_slot_s;
    Addr_A    = {AW{1'b0}};
    Addr_B    = {AW{1'b0}};
    Tw_Addr   = {JW{1'b0}};
    if (wr_slot_s) begin
      Addr_A = head_a_s;
      Addr_B = head_a_s + half_s;
    end else if (rd_slot_s) begin
      Addr_A  = rd_a_s;
      Addr_B  = rd_a_s + half_s;
      Tw_Addr = pos_s << tw_sh_s;
    end else begin
      Tw_Addr = {JW{1'b0}};
    end
  end

  // Sequencing; the drain before each stage advance keeps stage s+1 reads behind stage s writes.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    j_d      = j_q;
    infl_d   = infl_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q | bad_res_s;
    if (rd_slot_s) begin
      infl_d   = infl_q + CW'(1'b1);
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
      j_d      = j_q + JW'(1'b1);
    end else if (wr_slot_s) begin
      infl_d   = infl_q - CW'(1'b1);
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      infl_d = infl_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          stage_d = {SW{1'b0}};
          j_d     = {JW{1'b0}};
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rd_slot_s && (j_q == LAST_J)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (infl_q == {CW{1'b0}}) begin
          if (stage_q == LAST_STAGE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + SW'(1'b1);
            j_d     = {JW{1'b0}};
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and pointers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_IDLE;
      stage_q       <= {SW{1'b0}};
      j_q           <= {JW{1'b0}};
      infl_q        <= {CW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      err_q         <= 1'b0;
      bf_in_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      j_q           <= j_d;
      infl_q        <= infl_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      err_q         <= err_d;
      bf_in_valid_q <= rd_slot_s;
    end
  end

  // Issued A addresses; entries are only read after being written, so no reset.
  always_ff @(posedge Clk) begin
    if (rd_slot_s) begin
      fifo_q[wr_ptr_q] <= rd_a_s;
    end
  end

  assign Busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign Done        = (state_q == ST_DONE);
  assign Err         = err_q;
  assign Stage       = stage_q;
  assign Bf_In_Valid = bf_in_valid_q;

endmodule

// File: tb/tb_fft_mem_sched.sv
// Bench for fft_mem_sched: behavioural memory + butterfly with random latency, address and
// ordering model per stage, and a golden in-place transform compared after Done.
module tb_fft_mem_sched;
  logic       Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0, Bf_Res_Valid = 1'b0;
  logic       Busy, Done, Err, En, We_A, We_B, Bf_In_Valid;
  logic [2:0] Stage;
  logic [7:0] Addr_A, Addr_B;
  logic [6:0] Tw_Addr;

  fft_mem_sched dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Busy(Busy), .Done(Done), .Err(Err),
    .Stage(Stage), .En(En), .We_A(We_A), .We_B(We_B), .Addr_A(Addr_A), .Addr_B(Addr_B),
    .Tw_Addr(Tw_Addr), .Bf_In_Valid(Bf_In_Valid), .Bf_Res_Valid(Bf_Res_Valid)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [63:0] a; logic [63:0] b; int rdy; } res_t;
  typedef struct { logic [7:0] a; logic [7:0] b; } pair_t;

  int          total = 0, bad = 0;
  logic [63:0] mem  [256];
  logic [63:0] gold [256];
  res_t        res_q[$];
  pair_t       iss_q[$];
  int          cyc = 0, lat = 4, jit = 0, last_rdy = 0;
  int          m_inflight = 0, m_s = 0, m_j = 0, n_rd = 0, n_wr = 0, n_done = 0, max_infl = 0;
  bit          m_running = 0, m_err = 0, prev_rd = 0, force_res = 0, start_req = 0;
  logic [63:0] cap_a, cap_b;
  logic [6:0]  cap_tw;
  logic [2:0]  last_stage = 3'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void bf(input logic [63:0] a, input logic [63:0] b, input logic [6:0] tw,
                             output logic [63:0] oa, output logic [63:0] ob);
    logic [31:0] wr, wi, tr, ti;
    wr = {25'd0, tw} * 32'd3 + 32'd1;
    wi = {25'd0, tw} ^ 32'h0000_05A5;
    tr = wr * b[63:32] - wi * b[31:0];
    ti = wr * b[31:0] + wi * b[63:32];
    oa = {a[63:32] + tr, a[31:0] + ti};
    ob = {a[63:32] - tr, a[31:0] - ti};
  endfunction

  function automatic void golden();
    logic [63:0] oa, ob;
    for (int s = 0; s < 8; s++) begin
      for (int g = 0; g < (128 >> s); g++) begin
        for (int p = 0; p < (1 << s); p++) begin
          int a = g * 2 * (1 << s) + p;
          int b = a + (1 << s);
          bf(gold[a], gold[b], 7'(p * (128 >> s)), oa, ob);
          gold[a] = oa;
          gold[b] = ob;
        end
      end
    end
  endfunction

  task automatic step();
    bit rd, wr, bad_res, acc;
    int half, grp, pos, ea;
    logic [63:0] oa, ob;
    res_t r;
    pair_t p;
    bad_res = Bf_Res_Valid && (!m_running || m_inflight == 0);
    acc = Start && !m_running && !Done;
    if (prev_rd) begin
      bf(cap_a, cap_b, cap_tw, oa, ob);
      r.a = oa; r.b = ob;
      r.rdy = cyc + lat + $urandom_range(0, jit);
      if (r.rdy <= last_rdy) r.rdy = last_rdy + 1;
      last_rdy = r.rdy;
      res_q.push_back(r);
    end
    chk("bf_in_valid", Bf_In_Valid, prev_rd);
    chk("err", Err, m_err);
    if (Stage !== last_stage) begin
      if (m_running) chk("stage_barrier", m_inflight, 0);
      last_stage = Stage;
    end
    rd = En && !We_A && !We_B;
    wr = En && We_A && We_B;
    if (Bf_Res_Valid && !bad_res) begin
      chk("wr_slot", wr, 1);
      p = iss_q.pop_front();
      r = res_q.pop_front();
      chk("wr_addr_a", Addr_A, p.a);
      chk("wr_addr_b", Addr_B, p.b);
      mem[Addr_A] = r.a;
      mem[Addr_B] = r.b;
      m_inflight--;
      n_wr++;
    end else begin
      chk("no_write", We_A | We_B, 0);
      if (bad_res) begin
        chk("no_en_on_bad_res", En, 0);
      end else begin
        if (m_running && m_j > 0 && m_j < 128 && m_inflight < 8) chk("rd_expected", rd, 1);
        if (rd) begin
          chk("rd_legal", m_running && m_inflight < 8, 1);
          if (m_j == 128) begin
            chk("rd_barrier", m_inflight, 0);
            chk("rd_extra", m_s < 7, 1);
            m_s++;
            m_j = 0;
          end
          half = 1 << m_s;
          grp  = m_j / half;
          pos  = m_j % half;
          ea   = grp * 2 * half + pos;
          chk("rd_stage", Stage, m_s);
          chk("rd_addr_a", Addr_A, ea);
          chk("rd_addr_b", Addr_B, ea + half);
          chk("rd_tw", Tw_Addr, pos * (128 / half));
          if (m_s == 0 && m_j == 0) begin
            chk("s0j0_a", Addr_A, 0); chk("s0j0_b", Addr_B, 1); chk("s0j0_tw", Tw_Addr, 0);
          end
          if (m_s == 2 && m_j == 5) begin
            chk("s2j5_a", Addr_A, 9); chk("s2j5_b", Addr_B, 13); chk("s2j5_tw", Tw_Addr, 32);
          end
          if (m_s == 7 && m_j == 5) begin
            chk("s7j5_a", Addr_A, 5); chk("s7j5_b", Addr_B, 133); chk("s7j5_tw", Tw_Addr, 5);
          end
          p.a = Addr_A; p.b = Addr_B;
          iss_q.push_back(p);
          cap_a = mem[Addr_A]; cap_b = mem[Addr_B]; cap_tw = Tw_Addr;
          m_inflight++;
          if (m_inflight > max_infl) max_infl = m_inflight;
          m_j++;
          n_rd++;
        end
      end
    end
    if (Done) begin
      n_done++;
      chk("busy_at_done", Busy, 0);
      chk("reads_at_done", n_rd, 1024);
      chk("writes_at_done", n_wr, 1024);
      m_running = 0;
    end else begin
      chk("busy", Busy, m_running);
    end
    prev_rd = rd;
    if (acc) begin
      m_running = 1; m_s = 0; m_j = 0; n_rd = 0; n_wr = 0; m_err = 0;
    end else if (bad_res) begin
      m_err = 1;
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    cyc++;
    Bf_Res_Valid = force_res || (res_q.size() > 0 && res_q[0].rdy <= cyc);
    Start = start_req;
    start_req = 0;
    force_res = 0;
    #1;
    step();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0; Bf_Res_Valid = 1'b0; Start = 1'b0;
    #1;
    chk("rst_busy", Busy, 0);   chk("rst_done", Done, 0);   chk("rst_err", Err, 0);
    chk("rst_en", En, 0);       chk("rst_we_a", We_A, 0);   chk("rst_we_b", We_B, 0);
    chk("rst_bfv", Bf_In_Valid, 0); chk("rst_stage", Stage, 0);
    chk("rst_addr_a", Addr_A, 0);   chk("rst_addr_b", Addr_B, 0); chk("rst_tw", Tw_Addr, 0);
    res_q.delete(); iss_q.delete();
    m_running = 0; m_err = 0; prev_rd = 0; m_inflight = 0; m_s = 0; m_j = 0;
    last_stage = 3'd0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic run_fft(input int l, input int j, input int mid_start, input int abort_stage);
    int nmis;
    lat = l; jit = j; max_infl = 0; n_done = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {$urandom(), $urandom()};
      gold[i] = mem[i];
    end
    golden();
    start_req = 1;
    for (int c = 0; c < 20000; c++) begin
      if (c == mid_start) start_req = 1;
      tick();
      if (abort_stage >= 0 && m_s == abort_stage && m_j == 40) begin
        do_reset();
        return;
      end
      if (n_done > 0) break;
    end
    chk("done_seen", n_done, 1);
    repeat (3) tick();
    chk("done_once", n_done, 1);
    chk("stage_held_idle", Stage, 7);
    chk("busy_idle", Busy, 0);
    chk("inflight_le_depth", max_infl <= 8, 1);
    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) nmis++;
    chk("mem_vs_golden", nmis, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    force_res = 1;
    tick();
    tick();
    chk("err_after_idle_res", Err, 1);
    run_fft(4, 0, 500, -1);
    run_fft(20, 3, -1, -1);
    chk("inflight_full", max_infl, 8);
    run_fft($urandom_range(1, 12), 2, -1, 3);
    run_fft($urandom_range(1, 10), 4, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
